cp0_trap_sequencer: RTL and testbench

Sequences exception entry and ERET return through the CP0 register block. Arbitrates pending trap requests from the MEM stage and the external interrupt line, gates them with the Status enable bits, and issues one-cycle `exception`/`eret` commands with the matching cause and PC. It then flushes the pipeline and holds a PC redirect until fetch accepts it.

---
 rtl/cp0_trap_sequencer_if.sv | 29 ++
 rtl/cp0_trap_sequencer.sv | 60 ++++++
 tb/tb_cp0_trap_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/cp0_trap_sequencer_if.sv
// cp0_trap_sequencer_if: pipeline/CP0/fetch signals around the trap sequencer
interface cp0_trap_sequencer_if;
  logic        irq;
  logic        req_syscall;
  logic        req_break;
  logic        req_teq;
  logic        req_eret;
  logic [31:0] req_pc;
  logic [31:0] status;
  logic [31:0] epc;
  logic        exception;
  logic        eret;
  logic [31:0] cause;
  logic [31:0] pc_out;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ack;
  logic        busy;
  modport master (
    output irq, req_syscall, req_break, req_teq, req_eret, req_pc, status, epc, redirect_ack,
    input  exception, eret, cause, pc_out, stall, flush, redirect_valid, redirect_pc, busy
  );
  modport slave (
    input  irq, req_syscall, req_break, req_teq, req_eret, req_pc, status, epc, redirect_ack,
    output exception, eret, cause, pc_out, stall, flush, redirect_valid, redirect_pc, busy
  );
endinterface

// File: rtl/cp0_trap_sequencer.sv
// cp0_trap_sequencer: arbitrates traps/ERET, strobes CP0 and holds a fetch redirect
module cp0_trap_sequencer #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input logic clk,
  input logic rst,
  cp0_trap_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, TRAP, RET, REDIR} state_t;
  state_t state, state_n;
  logic [31:0] cause_q, pc_q, redir_q;
  logic i_irq, i_sys, i_brk, i_teq, i_exc, idle, take;
  logic [4:0] code;
  assign idle  = state == IDLE;
  assign i_irq = bus.irq & bus.status[0];
  assign i_sys = bus.req_syscall & bus.status[0] & bus.status[1];
  assign i_brk = bus.req_break & bus.status[0] & bus.status[2];
  assign i_teq = bus.req_teq & bus.status[0] & bus.status[3];
  assign i_exc = i_irq | i_sys | i_brk | i_teq;
  assign take  = idle & (i_exc | bus.req_eret);
  assign code  = i_irq ? 5'd0 : i_sys ? 5'd8 : i_brk ? 5'd9 : 5'd13;
  // Next state: exceptions win over ERET; REDIR dwells until fetch acks
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = i_exc ? TRAP : bus.req_eret ? RET : IDLE;
      TRAP:  state_n = REDIR;
      RET:   state_n = REDIR;
      REDIR: state_n = bus.redirect_ack ? IDLE : REDIR;
      default: state_n = IDLE;
    endcase
  end
  // State plus the CP0 write data and redirect target captured on entry
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cause_q <= '0;
      pc_q    <= '0;
      redir_q <= '0;
    end else begin
      state <= state_n;
      if (idle && i_exc) begin
        cause_q <= {25'b0, code, 2'b0};
        pc_q    <= bus.req_pc;
        redir_q <= EXC_VECTOR;
      end else if (state == RET) begin
        redir_q <= bus.epc;
      end
    end
  end
  assign bus.exception      = state == TRAP;
  assign bus.eret           = state == RET;
  assign bus.flush          = state == REDIR;
  assign bus.redirect_valid = state == REDIR;
  assign bus.busy           = !idle;
  assign bus.stall          = rst & (!idle | take);
  assign bus.cause          = cause_q;
  assign bus.pc_out         = pc_q;
  assign bus.redirect_pc    = redir_q;
endmodule

// File: tb/tb_cp0_trap_sequencer.sv
// tb_cp0_trap_sequencer: directed checks of trap/ERET sequencing
module tb_cp0_trap_sequencer;
  logic clk = 0;
  logic rst = 0;
  int checks = 0;
  int failures = 0;
  cp0_trap_sequencer_if bus();
  cp0_trap_sequencer #(.EXC_VECTOR(32'h0000_4180)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(negedge clk);
    #1;
  endtask
  task automatic clear_reqs;
    bus.irq = 0;
    bus.req_syscall = 0;
    bus.req_break = 0;
    bus.req_teq = 0;
    bus.req_eret = 0;
  endtask
  // Called in the accept cycle after the request is set up
  task automatic seq(input string tag, input bit is_eret, input logic [31:0] exp_cause,
                     input logic [31:0] exp_pc, input logic [31:0] exp_redir);
    check({tag, "_stall_n"}, bus.stall, 1);
    check({tag, "_busy_n"}, bus.busy, 0);
    cyc;
    clear_reqs;
    check({tag, "_exc"}, bus.exception, !is_eret);
    check({tag, "_eret"}, bus.eret, is_eret);
    if (!is_eret) begin
      check({tag, "_cause"}, bus.cause, exp_cause);
      check({tag, "_pc_out"}, bus.pc_out, exp_pc);
    end
    check({tag, "_stall_t"}, bus.stall, 1);
    cyc;
    check({tag, "_flush"}, bus.flush, 1);
    check({tag, "_rv"}, bus.redirect_valid, 1);
    check({tag, "_rpc"}, bus.redirect_pc, exp_redir);
    check({tag, "_strobe_r"}, {bus.exception, bus.eret}, 0);
    check({tag, "_stall_r"}, bus.stall, 1);
    bus.redirect_ack = 1;
    cyc;
    bus.redirect_ack = 0;
    check({tag, "_busy_i"}, bus.busy, 0);
    check({tag, "_stall_i"}, bus.stall, 0);
    check({tag, "_flush_i"}, bus.flush, 0);
  endtask
  initial begin
    clear_reqs;
    bus.req_pc = 0;
    bus.status = 0;
    bus.epc = 0;
    bus.redirect_ack = 0;
    bus.status = 32'h1;
    bus.irq = 1;
    cyc;
    cyc;
    check("rst_stall", bus.stall, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_out", {bus.exception, bus.eret, bus.flush, bus.redirect_valid}, 0);
    check("rst_cause", bus.cause, 0);
    check("rst_pc_out", bus.pc_out, 0);
    check("rst_rpc", bus.redirect_pc, 0);
    clear_reqs;
    rst = 1;
    cyc;
    // syscall
    bus.status = 32'h3;
    bus.req_syscall = 1;
    bus.req_pc = 32'h0040_0010;
    #1;
    seq("sys", 0, 32'h20, 32'h0040_0010, 32'h0000_4180);
    // priority irq over break and eret
    bus.status = 32'hF;
    bus.irq = 1;
    bus.req_break = 1;
    bus.req_eret = 1;
    bus.req_pc = 32'h0040_0100;
    #1;
    seq("pri_irq", 0, 32'h00, 32'h0040_0100, 32'h0000_4180);
    bus.req_break = 1;
    bus.req_teq = 1;
    bus.req_pc = 32'h0040_0200;
    #1;
    seq("pri_brk", 0, 32'h24, 32'h0040_0200, 32'h0000_4180);
    // masking
    bus.status = 32'h1;
    bus.req_teq = 1;
    #1;
    check("mask_teq_stall", bus.stall, 0);
    cyc;
    check("mask_teq_busy", bus.busy, 0);
    check("mask_teq_exc", bus.exception, 0);
    clear_reqs;
    bus.status = 32'h0;
    bus.irq = 1;
    #1;
    check("mask_irq_stall", bus.stall, 0);
    cyc;
    check("mask_irq_busy", bus.busy, 0);
    check("mask_irq_exc", bus.exception, 0);
    clear_reqs;
    // eret
    bus.req_eret = 1;
    bus.epc = 32'h0040_0024;
    #1;
    seq("eret", 1, 0, 0, 32'h0040_0024);
    // ack hold with a syscall arriving during the dwell
    bus.status = 32'h3;
    bus.req_syscall = 1;
    bus.req_pc = 32'h0040_0300;
    cyc;
    clear_reqs;
    cyc;
    bus.req_syscall = 1;
    for (int i = 0; i < 4; i++) begin
      check("hold_rv", bus.redirect_valid, 1);
      check("hold_flush", bus.flush, 1);
      check("hold_stall", bus.stall, 1);
      check("hold_rpc", bus.redirect_pc, 32'h0000_4180);
      check("hold_exc", bus.exception, 0);
      cyc;
    end
    clear_reqs;
    check("hold_pc_out", bus.pc_out, 32'h0040_0300);
    bus.redirect_ack = 1;
    cyc;
    bus.redirect_ack = 0;
    check("hold_busy_i", bus.busy, 0);
    check("hold_exc_i", bus.exception, 0);
    // reset during TRAP
    bus.req_syscall = 1;
    bus.req_pc = 32'h0040_0400;
    cyc;
    clear_reqs;
    check("rt_in_trap", bus.exception, 1);
    rst = 0;
    #1;
    check("rt_stall_rst", bus.stall, 0);
    cyc;
    check("rt_busy", bus.busy, 0);
    check("rt_exc", bus.exception, 0);
    check("rt_cause", bus.cause, 0);
    check("rt_pc_out", bus.pc_out, 0);
    rst = 1;
    // reset during REDIR
    bus.status = 32'h1;
    bus.irq = 1;
    cyc;
    clear_reqs;
    cyc;
    check("rr_in_redir", bus.redirect_valid, 1);
    rst = 0;
    cyc;
    check("rr_rv", bus.redirect_valid, 0);
    check("rr_flush", bus.flush, 0);
    check("rr_rpc", bus.redirect_pc, 0);
    check("rr_busy", bus.busy, 0);
    rst = 1;
    cyc;
    // fresh request after reset
    bus.status = 32'h9;
    bus.req_teq = 1;
    bus.req_pc = 32'h0040_0500;
    #1;
    seq("teq", 0, 32'h34, 32'h0040_0500, 32'h0000_4180);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
